// File: rtl/mem_dp_pkg.sv
// rtl/mem_dp_pkg.sv - shared types, limits and byte-merge helper for the local RAM
package mem_dp_pkg;

  typedef enum logic {CLEAR, RUN} mem_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word be_merge can handle; callers zero-extend and drop the upper bits.
  localparam int MERGE_W = 512;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]   old_word,
    input logic [MERGE_W-1:0]   new_word,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_dp_if.sv
// rtl/mem_dp_if.sv - write/read request and response signals of the local RAM
interface mem_dp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_be;
  logic              wr_err;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              rd_err;
  logic              init_done;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr,
    input  wr_ready, wr_err, rd_ready, rd_rvalid, rd_rdata, rd_err, init_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr,
    output wr_ready, wr_err, rd_ready, rd_rvalid, rd_rdata, rd_err, init_done
  );
endinterface

// File: rtl/mem_dp_array.sv
// rtl/mem_dp_array.sv - DEPTH x DATA_W storage, byte-enable write, registered read
module mem_dp_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write word on a same-address collision; the top merges.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_dp_ctrl.sv
// rtl/mem_dp_ctrl.sv - local RAM controller: post-reset clear, range checks, bypass, read latency
module mem_dp_ctrl
  import mem_dp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  mem_dp_if.slave  bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W   = DATA_W / 8;

  if ((DATA_W % 8) != 0 || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || DATA_W >= MERGE_W) begin : g_bad_param
    $error("mem_dp_ctrl: illegal DATA_W=%0d or RD_LAT=%0d", DATA_W, RD_LAT);
  end

  mem_state_e        state, state_n;
  logic [ADDR_W-1:0] clr_cnt;
  logic              run;
  logic              wr_acc, wr_in, rd_acc, rd_in;

  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic [BE_W-1:0]   arr_wbe;

  logic              wr_err_q;
  logic              s1_valid, s1_err, s1_byp;
  logic [DATA_W-1:0] s1_wdata, s1_data, merged;
  logic [BE_W-1:0]   s1_be;
  logic [MERGE_W-DATA_W-1:0] unused_merge_hi;

  assign run    = (state == RUN);
  assign wr_in  = ({1'b0, bus.wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in  = ({1'b0, bus.rd_addr} < (ADDR_W+1)'(DEPTH));
  assign wr_acc = bus.wr_valid && run && !rst;
  assign rd_acc = bus.rd_valid && run && !rst;
  assign arr_re = rd_acc && rd_in;

  always_comb begin
    state_n   = state;
    arr_we    = 1'b0;
    arr_waddr = bus.wr_addr;
    arr_wdata = bus.wr_data;
    arr_wbe   = bus.wr_be;
    case (state)
      CLEAR: begin
        arr_we    = !rst;
        arr_waddr = clr_cnt;
        arr_wdata = '0;
        arr_wbe   = '1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) state_n = RUN;
      end
      RUN:     arr_we = wr_acc && wr_in;
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      wr_err_q <= 1'b0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      state    <= state_n;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
      wr_err_q <= wr_acc && !wr_in;
      s1_valid <= rd_acc;
      s1_err   <= rd_acc && !rd_in;
    end
  end

  // Bypass bookkeeping only matters while s1_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_byp   <= arr_re && wr_acc && (bus.wr_addr == bus.rd_addr);
    s1_wdata <= bus.wr_data;
    s1_be    <= bus.wr_be;
  end

  mem_dp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wbe   (arr_wbe),
    .re    (arr_re),
    .raddr (bus.rd_addr),
    .rdata (arr_rdata)
  );

  assign {unused_merge_hi, merged} =
    be_merge(MERGE_W'(arr_rdata), MERGE_W'(s1_wdata), (MERGE_W/8)'(s1_be));
  assign s1_data = s1_err ? '0 : (s1_byp ? merged : arr_rdata);

  assign bus.wr_ready  = run;
  assign bus.rd_ready  = run;
  assign bus.init_done = run;
  assign bus.wr_err    = wr_err_q;

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid, s2_err;
    logic [DATA_W-1:0] s2_data;
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_err   <= s1_valid && s1_err;
        if (s1_valid) s2_data <= s1_data;
      end
    end
    assign bus.rd_rvalid = s2_valid;
    assign bus.rd_err    = s2_err;
    assign bus.rd_rdata  = s2_data;
  end else begin : g_lat1
    // Holds the last response so rd_rdata stays stable between pulses.
    logic [DATA_W-1:0] hold_q;
    always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else if (s1_valid) hold_q <= s1_data;
    end
    assign bus.rd_rvalid = s1_valid;
    assign bus.rd_err    = s1_valid && s1_err;
    assign bus.rd_rdata  = s1_valid ? s1_data : hold_q;
  end

endmodule
